micro_sequencer: RTL and testbench
==================================

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 8, giving the control-store address width.
REQ-002 The block SHALL have parameter RESET_ADDR, default 8'd0, giving the first micro-address after start.
REQ-003 The block SHALL have parameter JMPZY, default 8'd50, giving the target when jump_z is set and z_flag=1.
REQ-004 The block SHALL have parameter JMPZN, default 8'd48, giving the target when jump_z is set and z_flag=0.
REQ-005 The block SHALL have parameter DEPTH, default 4, giving the number of micro-call return-stack entries.
REQ-006 clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous and active-low.
REQ-008 start  in  1  leave IDLE/HALT and begin at RESET_ADDR.
REQ-009 halt_req  in  1  stop sequencing.
REQ-010 next_addr  in  ADDRWIDTH  NEXT field of the current microinstruction.
REQ-011 addr_sel  in  1  dispatch to mbru.
REQ-012 mbru  in  ADDRWIDTH  opcode byte used for dispatch.
REQ-013 jump_z  in  1  conditional branch on z_flag.
REQ-014 z_flag  in  1  ALU zero flag.
REQ-015 call  in  1  push next_addr and go to call_addr.
REQ-016 call_addr  in  ADDRWIDTH  subroutine entry.
REQ-017 ret  in  1  pop the return address and go there.
REQ-018 mem_busy  in  1  datapath memory not ready; stall.
REQ-019 cs_addr  out  ADDRWIDTH  registered control-store address (MPC).
REQ-020 cs_en  out  1  control-store read enable; microinstruction valid.
REQ-021 running  out  1  high in RUN or STALL.
REQ-022 err  out  1  sticky stack fault or illegal call+ret.

Function
REQ-023 The FSM SHALL have states IDLE, RUN, STALL and HALT.
REQ-024 IDLE: cs_en=0 and cs_addr=RESET_ADDR; on start, go to RUN with cs_addr=RESET_ADDR, cs_en=1, stack emptied and err cleared.
REQ-025 RUN with mem_busy=0: the next cs_addr SHALL be chosen by priority addr_sel→mbru, then jump_z→(z_flag?JMPZY:JMPZN), then call→call_addr, then ret→popped address, else next_addr; it is registered with 1-cycle latency.
REQ-026 RUN with mem_busy=1: go to STALL; cs_addr, stack and depth SHALL be held and cs_en SHALL stay 1.
REQ-027 STALL: hold everything; when mem_busy=0, evaluate REQ-025 in that same cycle and return to RUN.
REQ-028 call (when selected by REQ-025) SHALL push next_addr and increment depth; ret SHALL pop the top entry and decrement depth.
REQ-029 A call with depth=DEPTH SHALL NOT push or jump; it SHALL set err and go to HALT.
REQ-030 A ret with depth=0 SHALL set err and go to HALT.
REQ-031 call and ret together, with no higher-priority selection active, SHALL set err and go to HALT with the stack unchanged.
REQ-032 A call or ret masked by addr_sel or jump_z SHALL NOT change the stack.
REQ-033 halt_req in RUN or STALL SHALL go to HALT next cycle, overriding all else except rst_n; cs_en=0 and cs_addr is held.
REQ-034 HALT: cs_en=0; start SHALL behave as in IDLE (restart at RESET_ADDR, stack empty, err cleared); start and halt_req together in HALT SHALL stay in HALT.
REQ-035 In IDLE or HALT, the inputs call, ret, jump_z and addr_sel SHALL be ignored.
REQ-036 Address arithmetic SHALL be unsigned ADDRWIDTH, with no increment and no wrap logic.
REQ-037 running SHALL be high only in RUN or STALL.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force IDLE, cs_addr=RESET_ADDR, cs_en=0, running=0, err=0 and depth=0, overriding all inputs, including mid-stall and mid-call.
REQ-039 Stack entry contents SHALL not need reset; only depth SHALL be reset.

Structure
REQ-040 The state encoding, RESET_ADDR, JMPZY and JMPZN SHALL live in the shared processor package.
REQ-041 The return stack SHALL be the sub-module micro_stack, with push, pop, full, empty and top ports and DEPTH entries.

Verification
REQ-042 After reset, start, then next_addr=5 → cs_addr sequence 0, 5 with cs_en=1 from the cycle after start.
REQ-043 In RUN, jump_z=1 with z_flag=1 → cs_addr=50; with z_flag=0 → cs_addr=48; addr_sel=1, mbru=8'h3C and jump_z=1 together → cs_addr=8'h3C.
REQ-044 call with call_addr=20 and next_addr=7, then ret → cs_addr 20 then 7; a 5th nested call → err=1, HALT, cs_en=0.
REQ-045 mem_busy held high 3 cycles while next_addr=9 → cs_addr is held for 3 cycles, then becomes 9.
REQ-046 halt_req in STALL → HALT; rst_n=0 mid-subroutine → IDLE, depth=0; then start → cs_addr=0.

Source files
------------

// File: rtl/micro_sequencer_pkg.sv
// Shared processor definitions for the microcode sequencer: FSM encoding and
// the fixed micro-addresses used for restart and the zero-flag branch.
package micro_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_HALT  = 2'd3
  } seq_state_t;

  localparam logic [7:0] DEF_RESET_ADDR = 8'd0;
  localparam logic [7:0] DEF_JMPZY      = 8'd50;
  localparam logic [7:0] DEF_JMPZN      = 8'd48;

endpackage

// File: rtl/micro_stack.sv
// Return-address stack for micro-calls. Only the occupancy counter is reset;
// entry contents are don't-care until pushed.
module micro_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]    depth_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_sel;

  assign full  = (depth_reg == CW'(DEPTH));
  assign empty = (depth_reg == '0);

  // The free slot is the one indexed by the current depth.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
    assign wr_sel[gi] = push && !full && (depth_reg == CW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i]) mem[i] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      depth_reg <= '0;
    end else if (push && !full) begin
      depth_reg <= depth_reg + 1'b1;
    end else if (pop && !empty) begin
      depth_reg <= depth_reg - 1'b1;
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_reg == CW'(i + 1)) top = mem[i];
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram counter: picks the next control-store address from dispatch,
// zero-flag branch, call/return or the NEXT field, with stall and halt control.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int                   ADDRWIDTH  = 8,
  parameter logic [ADDRWIDTH-1:0] RESET_ADDR = ADDRWIDTH'(DEF_RESET_ADDR),
  parameter logic [ADDRWIDTH-1:0] JMPZY      = ADDRWIDTH'(DEF_JMPZY),
  parameter logic [ADDRWIDTH-1:0] JMPZN      = ADDRWIDTH'(DEF_JMPZN),
  parameter int                   DEPTH      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt_req,
  input  logic [ADDRWIDTH-1:0] next_addr,
  input  logic                 addr_sel,
  input  logic [ADDRWIDTH-1:0] mbru,
  input  logic                 jump_z,
  input  logic                 z_flag,
  input  logic                 call,
  input  logic [ADDRWIDTH-1:0] call_addr,
  input  logic                 ret,
  input  logic                 mem_busy,
  output logic [ADDRWIDTH-1:0] cs_addr,
  output logic                 cs_en,
  output logic                 running,
  output logic                 err
);

  seq_state_t           state_reg, state_next;
  logic [ADDRWIDTH-1:0] addr_next;
  logic                 err_next;
  logic                 stk_push, stk_pop, stk_clear;
  logic [ADDRWIDTH-1:0] stk_top;
  logic                 stk_full, stk_empty;

  micro_stack #(
    .DEPTH (DEPTH),
    .WIDTH (ADDRWIDTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (stk_clear),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (next_addr),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cs_addr   <= RESET_ADDR;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cs_addr   <= addr_next;
      err       <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = cs_addr;
    err_next   = err;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_clear  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_HALT: begin
        // A start together with halt_req keeps a halted sequencer halted.
        if (start && !(state_reg == ST_HALT && halt_req)) begin
          state_next = ST_RUN;
          addr_next  = RESET_ADDR;
          stk_clear  = 1'b1;
          err_next   = 1'b0;
        end
      end
      ST_RUN, ST_STALL: begin
        if (halt_req) begin
          state_next = ST_HALT;
        end else if (mem_busy) begin
          state_next = ST_STALL;
        end else begin
          state_next = ST_RUN;
          if (addr_sel) begin
            addr_next = mbru;
          end else if (jump_z) begin
            addr_next = z_flag ? JMPZY : JMPZN;
          end else if (call && ret) begin
            err_next   = 1'b1;
            state_next = ST_HALT;
          end else if (call) begin
            if (stk_full) begin
              err_next   = 1'b1;
              state_next = ST_HALT;
            end else begin
              stk_push  = 1'b1;
              addr_next = call_addr;
            end
          end else if (ret) begin
            if (stk_empty) begin
              err_next   = 1'b1;
              state_next = ST_HALT;
            end else begin
              stk_pop   = 1'b1;
              addr_next = stk_top;
            end
          end else begin
            addr_next = next_addr;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign running = (state_reg == ST_RUN) || (state_reg == ST_STALL);
  assign cs_en   = running;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus a randomized run, all
// checked against a queue-based behavioural model of the sequencer.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, halt_req, addr_sel, jump_z, z_flag, call, ret, mem_busy;
  logic [7:0] next_addr, mbru, call_addr;
  logic [7:0] cs_addr;
  logic       cs_en, running, err;

  int checks = 0;
  int failures = 0;

  // Model: mode 0 idle, 1 run, 2 stall, 3 halt.
  int         m_mode;
  logic [7:0] m_addr;
  logic       m_err;
  logic [7:0] m_stack[$];

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .next_addr(next_addr), .addr_sel(addr_sel), .mbru(mbru), .jump_z(jump_z),
    .z_flag(z_flag), .call(call), .call_addr(call_addr), .ret(ret),
    .mem_busy(mem_busy), .cs_addr(cs_addr), .cs_en(cs_en), .running(running),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    start = 0; halt_req = 0; addr_sel = 0; jump_z = 0; z_flag = 0;
    call = 0; ret = 0; mem_busy = 0; next_addr = 0; mbru = 0; call_addr = 0;
  endtask

  task automatic model_restart();
    m_mode = 1; m_addr = 8'd0; m_err = 0; m_stack.delete();
  endtask

  // Advance the model by one clock from the present inputs, then clock the DUT.
  task automatic cycle();
    if (!rst_n) begin
      m_mode = 0; m_addr = 8'd0; m_err = 0; m_stack.delete();
    end else if (m_mode == 0) begin
      if (start) model_restart();
    end else if (m_mode == 3) begin
      if (start && !halt_req) model_restart();
    end else if (halt_req) begin
      m_mode = 3;
    end else if (mem_busy) begin
      m_mode = 2;
    end else begin
      m_mode = 1;
      if (addr_sel) m_addr = mbru;
      else if (jump_z) m_addr = z_flag ? 8'd50 : 8'd48;
      else if (call && ret) begin m_err = 1; m_mode = 3; end
      else if (call) begin
        if (m_stack.size() == 4) begin m_err = 1; m_mode = 3; end
        else begin m_stack.push_back(next_addr); m_addr = call_addr; end
      end else if (ret) begin
        if (m_stack.size() == 0) begin m_err = 1; m_mode = 3; end
        else m_addr = m_stack.pop_back();
      end else m_addr = next_addr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    cycle(); cycle();
    checks++;
    if (cs_addr !== 8'd0 || cs_en !== 1'b0 || running !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset: addr=%0d en=%b run=%b err=%b required addr=0 en=0 run=0 err=0",
               cs_addr, cs_en, running, err);
    end
    rst_n = 1;
    next_addr = 8'd77; call = 1;
    cycle();
    checks++;
    if (cs_addr !== 8'd0 || cs_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignore: addr=%0d en=%b required addr=0 en=0", cs_addr, cs_en);
    end
    clear_inputs();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    start = 1;
    cycle();
    start = 0;
    checks++;
    if (cs_addr !== 8'd0 || cs_en !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL start: addr=%0d en=%b run=%b required addr=0 en=1 run=1", cs_addr, cs_en, running);
    end
    next_addr = 8'd5;
    cycle();
    checks++;
    if (cs_addr !== 8'd5 || cs_en !== 1'b1) begin
      failures++;
      $display("FAIL next_addr: addr=%0d en=%b required addr=5 en=1", cs_addr, cs_en);
    end
    $display("test_basic done");
  endtask

  task automatic test_branch();
    next_addr = 8'd11; jump_z = 1; z_flag = 1;
    cycle();
    checks++;
    if (cs_addr !== 8'd50) begin
      failures++; $display("FAIL jmpz_y: addr=%0d required 50", cs_addr);
    end
    z_flag = 0;
    cycle();
    checks++;
    if (cs_addr !== 8'd48) begin
      failures++; $display("FAIL jmpz_n: addr=%0d required 48", cs_addr);
    end
    addr_sel = 1; mbru = 8'h3C; call = 1; call_addr = 8'd99;
    cycle();
    checks++;
    if (cs_addr !== 8'h3C) begin
      failures++; $display("FAIL dispatch: addr=%0h required 3c", cs_addr);
    end
    // The masked call above must not have pushed: a ret now faults.
    clear_inputs(); ret = 1;
    cycle();
    checks++;
    if (err !== 1'b1 || cs_en !== 1'b0 || cs_addr !== 8'h3C) begin
      failures++;
      $display("FAIL masked_call: err=%b en=%b addr=%0h required err=1 en=0 addr=3c", err, cs_en, cs_addr);
    end
    clear_inputs();
    $display("test_branch done");
  endtask

  task automatic test_call_ret();
    start = 1; cycle(); start = 0;
    checks++;
    if (err !== 1'b0 || cs_en !== 1'b1) begin
      failures++; $display("FAIL restart_clears_err: err=%b en=%b required err=0 en=1", err, cs_en);
    end
    call = 1; call_addr = 8'd20; next_addr = 8'd7;
    cycle();
    checks++;
    if (cs_addr !== 8'd20) begin
      failures++; $display("FAIL call: addr=%0d required 20", cs_addr);
    end
    call = 0; ret = 1; next_addr = 8'd1;
    cycle();
    checks++;
    if (cs_addr !== 8'd7) begin
      failures++; $display("FAIL ret: addr=%0d required 7", cs_addr);
    end
    ret = 0; call = 1;
    for (int i = 0; i < 4; i++) begin
      call_addr = 8'(30 + i); next_addr = 8'(i + 1);
      cycle();
      checks++;
      if (cs_addr !== 8'(30 + i) || err !== 1'b0) begin
        failures++;
        $display("FAIL nest_call%0d: addr=%0d err=%b required addr=%0d err=0", i, cs_addr, err, 30 + i);
      end
    end
    call_addr = 8'd60;
    cycle();
    checks++;
    if (err !== 1'b1 || cs_en !== 1'b0 || running !== 1'b0 || cs_addr !== 8'd33) begin
      failures++;
      $display("FAIL overflow: err=%b en=%b run=%b addr=%0d required err=1 en=0 run=0 addr=33",
               err, cs_en, running, cs_addr);
    end
    clear_inputs();
    $display("test_call_ret done");
  endtask

  task automatic test_stall();
    start = 1; cycle(); start = 0;
    next_addr = 8'd9; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (cs_addr !== 8'd0 || cs_en !== 1'b1 || running !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d: addr=%0d en=%b run=%b required addr=0 en=1 run=1", i, cs_addr, cs_en, running);
      end
    end
    mem_busy = 0;
    cycle();
    checks++;
    if (cs_addr !== 8'd9) begin
      failures++; $display("FAIL stall_release: addr=%0d required 9", cs_addr);
    end
    $display("test_stall done");
  endtask

  task automatic test_halt_reset();
    mem_busy = 1; cycle();
    halt_req = 1; cycle();
    checks++;
    if (running !== 1'b0 || cs_en !== 1'b0 || cs_addr !== 8'd9) begin
      failures++;
      $display("FAIL halt_in_stall: run=%b en=%b addr=%0d required run=0 en=0 addr=9", running, cs_en, cs_addr);
    end
    start = 1; cycle();
    checks++;
    if (running !== 1'b0) begin
      failures++; $display("FAIL start_with_halt: run=%b required 0", running);
    end
    halt_req = 0; mem_busy = 0; cycle(); start = 0;
    call = 1; call_addr = 8'd40; next_addr = 8'd3; cycle();
    call_addr = 8'd41; mem_busy = 1; rst_n = 0; cycle();
    checks++;
    if (cs_addr !== 8'd0 || cs_en !== 1'b0 || running !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_call: addr=%0d en=%b run=%b err=%b required 0 0 0 0", cs_addr, cs_en, running, err);
    end
    clear_inputs(); rst_n = 1;
    start = 1; cycle(); start = 0;
    checks++;
    if (cs_addr !== 8'd0 || cs_en !== 1'b1) begin
      failures++; $display("FAIL restart_after_reset: addr=%0d en=%b required addr=0 en=1", cs_addr, cs_en);
    end
    ret = 1; cycle(); ret = 0;
    checks++;
    if (err !== 1'b1 || running !== 1'b0) begin
      failures++; $display("FAIL ret_empty: err=%b run=%b required err=1 run=0", err, running);
    end
    start = 1; cycle(); start = 0;
    call = 1; ret = 1; cycle(); clear_inputs();
    checks++;
    if (err !== 1'b1 || running !== 1'b0 || cs_addr !== 8'd0) begin
      failures++; $display("FAIL call_and_ret: err=%b run=%b addr=%0d required err=1 run=0 addr=0", err, running, cs_addr);
    end
    $display("test_halt_reset done");
  endtask

  task automatic test_random();
    int bad = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      start     = ($urandom_range(0, 3) == 0);
      halt_req  = ($urandom_range(0, 29) == 0);
      addr_sel  = ($urandom_range(0, 7) == 0);
      jump_z    = ($urandom_range(0, 7) == 0);
      z_flag    = 1'($urandom);
      call      = ($urandom_range(0, 3) == 0);
      ret       = ($urandom_range(0, 3) == 0);
      mem_busy  = ($urandom_range(0, 3) == 0);
      next_addr = 8'($urandom);
      mbru      = 8'($urandom);
      call_addr = 8'($urandom);
      cycle();
      checks++;
      if (cs_addr !== m_addr || cs_en !== (m_mode == 1 || m_mode == 2) ||
          running !== (m_mode == 1 || m_mode == 2) || err !== m_err) begin
        failures++; bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: addr=%0d en=%b run=%b err=%b required addr=%0d mode=%0d err=%b",
                   n, cs_addr, cs_en, running, err, m_addr, m_mode, m_err);
      end
    end
    rst_n = 1;
    clear_inputs();
    $display("test_random done: 3000 cycles");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_branch();
    test_call_ret();
    test_stall();
    test_halt_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
